// File: rtl/div_unit.sv
// div_unit: multi-cycle restoring divider, one quotient bit per clock.
// Signed mode truncates toward zero; the remainder takes the dividend's sign.
// A zero divisor skips the iteration loop and reports all-ones / dividend.
`timescale 1ns/1ps
module div_unit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] DATA1,
  input  logic [WIDTH-1:0] DATA2,
  input  logic             SIGNED,
  input  logic             START,
  output logic [WIDTH-1:0] QUOTIENT,
  output logic [WIDTH-1:0] REMAINDER,
  output logic             BUSY,
  output logic             DONE,
  output logic             DIV_BY_ZERO
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StCalc, StFixup, StDone} state_e;

  state_e state_q, state_d;

  logic [CntW-1:0]  cnt_q;
  logic [WIDTH:0]   rem_q;     // partial remainder
  logic [WIDTH-1:0] dvd_q;     // dividend magnitude, shifts into the quotient
  logic [WIDTH-1:0] dvs_q;     // divisor magnitude
  logic             q_neg_q;
  logic             r_neg_q;
  logic             zero_q;    // current operation has a zero divisor
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rmd_q;
  logic             dbz_q;

  logic             accept;
  logic             zero_div;
  logic             sign1;
  logic             sign2;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] diff;

  assign accept   = START && ((state_q == StIdle) || (state_q == StDone));
  assign zero_div = (DATA2 == '0);
  assign sign1    = SIGNED & DATA1[WIDTH-1];
  assign sign2    = SIGNED & DATA2[WIDTH-1];
  // |-2^(W-1)| wraps to the same bit pattern, which is correct as unsigned.
  assign mag1     = sign1 ? -DATA1 : DATA1;
  assign mag2     = sign2 ? -DATA2 : DATA2;

  // Extra top bit on the difference keeps the trial sign exact when the
  // shifted remainder exceeds 2^W.
  assign shifted  = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign diff     = {1'b0, shifted} - {2'b00, dvs_q};

  // State register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a zero divisor goes straight to the result stage.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = zero_div ? StFixup : StCalc;
        end else begin
          state_d = StIdle;
        end
      end
      StCalc:  state_d = (cnt_q == '0) ? StFixup : StCalc;
      StFixup: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decoded from the state.
  always_comb begin
    BUSY = 1'b0;
    DONE = 1'b0;
    unique case (state_q)
      StCalc, StFixup: BUSY = 1'b1;
      StDone:          DONE = 1'b1;
      default:         ;
    endcase
  end

  // Datapath: operand capture, one restoring step per CALC cycle, sign fix-up.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      zero_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else if (accept) begin
      dbz_q   <= 1'b0;
      zero_q  <= zero_div;
      q_neg_q <= sign1 ^ sign2;
      r_neg_q <= sign1;
      // Raw dividend is kept for a zero divisor so it is reported unmodified.
      dvd_q   <= zero_div ? DATA1 : mag1;
      dvs_q   <= mag2;
      rem_q   <= '0;
      cnt_q   <= CntW'(WIDTH - 1);
    end else if (state_q == StCalc) begin
      rem_q <= diff[WIDTH+1] ? shifted : diff[WIDTH:0];
      dvd_q <= {dvd_q[WIDTH-2:0], ~diff[WIDTH+1]};
      cnt_q <= cnt_q - 1'b1;
    end else if (state_q == StFixup) begin
      if (zero_q) begin
        quo_q <= '1;
        rmd_q <= dvd_q;
        dbz_q <= 1'b1;
      end else begin
        quo_q <= q_neg_q ? -dvd_q : dvd_q;
        rmd_q <= r_neg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      end
    end
  end

  assign QUOTIENT    = quo_q;
  assign REMAINDER   = rmd_q;
  assign DIV_BY_ZERO = dbz_q;

endmodule
